// File: rtl/svi_bus_arbiter_if.sv
// Requester-side / bus-side bundle for svi_bus_arbiter.
//   i_req   : per-requester request level
//   i_last  : per-requester final-beat flag (only the owner's bit matters)
//   i_data  : requester data, requester k at [k*WIDTH +: WIDTH]
//   o_gnt   : one-hot registered grant
//   o_owner : index of current owner (valid with o_bus_vld)
//   o_bus   : shared bus value, zero when not valid
//   o_bus_vld : bus carries owner data
//   o_timeout : one-cycle pulse, grant ended by hold limit
// master modport = requester/consumer side, slave modport = arbiter.
interface svi_bus_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 8
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       i_req;
  logic [N_REQ-1:0]       i_last;
  logic [N_REQ*WIDTH-1:0] i_data;
  logic [N_REQ-1:0]       o_gnt;
  logic [OW-1:0]          o_owner;
  logic [WIDTH-1:0]       o_bus;
  logic                   o_bus_vld;
  logic                   o_timeout;

  modport master (
    output i_req, i_last, i_data,
    input  o_gnt, o_owner, o_bus, o_bus_vld, o_timeout
  );

  modport slave (
    input  i_req, i_last, i_data,
    output o_gnt, o_owner, o_bus, o_bus_vld, o_timeout
  );
endinterface

// File: rtl/svi_bus_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit bus between N_REQ requesters.
// Grants are registered and one-hot, limited to MAX_HOLD consecutive cycles,
// and every change of owner passes through exactly one idle TURN cycle so two
// drivers never overlap on the bus.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_if : svi_bus_arbiter_if.slave (requests, last, data in; grant, owner,
//            bus, bus valid, timeout out)
module svi_bus_arbiter #(
  parameter int N_REQ    = 3,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  svi_bus_arbiter_if.slave  bus_if
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, GNT, TURN} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             timeout_q, timeout_d;

  // Round-robin search split into two ascending scans: requesters above the
  // pointer take priority, otherwise the lowest requester at or below it wins.
  logic          hi_vld, lo_vld, win_vld;
  logic [OW-1:0] hi_idx, lo_idx, win_idx;

  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (bus_if.i_req[k]) begin
        if (OW'(k) > ptr_q) begin
          if (!hi_vld) begin
            hi_vld = 1'b1;
            hi_idx = OW'(k);
          end
        end else if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_idx = OW'(k);
        end
      end
    end
    win_vld = hi_vld | lo_vld;
    win_idx = hi_vld ? hi_idx : lo_idx;
  end

  logic own_last, own_req, hold_lim;

  always_comb begin
    own_last = bus_if.i_last[owner_q];
    own_req  = bus_if.i_req[owner_q];
    hold_lim = (hold_q == HW'(MAX_HOLD - 1));
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      GNT: begin
        hold_d = hold_q + HW'(1);
        if (own_last || !own_req || hold_lim) begin
          state_d   = TURN;
          gnt_d     = '0;
          hold_d    = '0;
          // Only a grant cut short purely by the hold limit is a timeout.
          timeout_d = hold_lim && own_req && !own_last;
        end
      end
      default: begin
        // IDLE and TURN both arbitrate; the turnaround is already paid in TURN.
        gnt_d = '0;
        if (win_vld) begin
          state_d = GNT;
          gnt_d   = N_REQ'(1) << win_idx;
          owner_d = win_idx;
          ptr_d   = win_idx;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= OW'(N_REQ - 1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  logic [WIDTH-1:0] bus_mux;

  always_comb begin
    bus_mux = '0;
    if (state_q == GNT) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (owner_q == OW'(k)) bus_mux = bus_if.i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign bus_if.o_gnt     = gnt_q;
  assign bus_if.o_owner   = owner_q;
  assign bus_if.o_bus     = bus_mux;
  assign bus_if.o_bus_vld = (state_q == GNT);
  assign bus_if.o_timeout = timeout_q;
endmodule

// File: tb/tb_svi_bus_arbiter.sv
module tb_svi_bus_arbiter;
  localparam int N_REQ    = 3;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 16;
  localparam int DW       = N_REQ * WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  svi_bus_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus_if ();

  svi_bus_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: who owns the bus, how many beats it has had, and where
  // the rotation resumes. Owner -1 means the bus is free (idle or turnaround).
  int m_owner;
  int m_beats;
  int m_ptr;
  bit m_to;
  int gq[$];        // owner of every new grant, in order
  int gnt_cycles;   // observed cycles with any grant
  int to_pulses;    // observed timeout pulses

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_ptr   = N_REQ - 1;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] last);
    bit found;
    if (m_owner >= 0) begin
      m_beats++;
      if (last[m_owner] || !req[m_owner] || m_beats == MAX_HOLD) begin
        m_to    = (m_beats == MAX_HOLD) && req[m_owner] && !last[m_owner];
        m_owner = -1;
      end else begin
        m_to = 1'b0;
      end
    end else begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
        int k;
        k = (m_ptr + i) % N_REQ;
        if (!found && req[k]) begin
          found   = 1'b1;
          m_owner = k;
          m_ptr   = k;
          m_beats = 0;
          gq.push_back(k);
        end
      end
    end
  endtask

  task automatic compare_all(input logic [DW-1:0] data);
    logic [N_REQ-1:0] e_gnt;
    logic [WIDTH-1:0] e_bus;
    e_gnt = '0;
    e_bus = '0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_bus = data[m_owner*WIDTH +: WIDTH];
    end
    check("gnt", 32'(bus_if.o_gnt), 32'(e_gnt));
    check("bus_vld", 32'(bus_if.o_bus_vld), 32'(m_owner >= 0));
    check("bus", 32'(bus_if.o_bus), 32'(e_bus));
    check("timeout", 32'(bus_if.o_timeout), 32'(m_to));
    if (m_owner >= 0) check("owner", 32'(bus_if.o_owner), 32'(m_owner));
    if (bus_if.o_gnt != '0) gnt_cycles++;
    if (bus_if.o_timeout) to_pulses++;
  endtask

  task automatic cycle(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] last,
                       input logic [DW-1:0] data);
    @(negedge clk);
    rst_n         = 1'b1;
    bus_if.i_req  = req;
    bus_if.i_last = last;
    bus_if.i_data = data;
    @(posedge clk);
    model_step(req, last);
    #1;
    compare_all(data);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'($urandom);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(bus_if.o_gnt), 32'h0);
    check({tag, "_vld"}, 32'(bus_if.o_bus_vld), 32'h0);
    check({tag, "_bus"}, 32'(bus_if.o_bus), 32'h0);
    check({tag, "_to"}, 32'(bus_if.o_timeout), 32'h0);
  endtask

  initial begin
    logic [DW-1:0] d;
    model_reset();
    gnt_cycles = 0;
    to_pulses  = 0;

    // Reset held with everyone requesting
    bus_if.i_req  = '1;
    bus_if.i_last = '1;
    bus_if.i_data = rnd_data();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_owner", 32'(bus_if.o_owner), 32'h0);

    // Release: last on first beat each time -> order 0,1,2,0
    for (int i = 0; i < 8; i++) cycle('1, '1, rnd_data());
    check("rr_n", 32'(gq.size()), 32'd4);
    if (gq.size() >= 4) begin
      check("rr0", 32'(gq[0]), 32'd0);
      check("rr1", 32'(gq[1]), 32'd1);
      check("rr2", 32'(gq[2]), 32'd2);
      check("rr3", 32'(gq[3]), 32'd0);
    end

    // Single grant to requester 1, last on third beat
    for (int i = 0; i < 3; i++) cycle('0, '0, rnd_data());
    gnt_cycles = 0;
    d = rnd_data();
    d[1*WIDTH +: WIDTH] = 8'hA5;
    for (int i = 0; i < 3; i++) cycle(3'b010, 3'b000, d);
    check("single_bus", 32'(bus_if.o_bus), 32'hA5);
    cycle(3'b010, 3'b010, d);
    check("single_turn_bus", 32'(bus_if.o_bus), 32'h00);
    for (int i = 0; i < 3; i++) cycle('0, '0, d);
    check("single_len", 32'(gnt_cycles), 32'd3);

    // Timeout: requester 0 held, never last
    to_pulses = 0;
    gq.delete();
    for (int i = 0; i < 1 + 3 * (MAX_HOLD + 1); i++) cycle(3'b001, 3'b000, rnd_data());
    check("to_pulses", 32'(to_pulses), 32'd3);
    check("to_regrants", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 3; i++) cycle('0, '0, rnd_data());

    // Async reset in the fifth beat of requester 1's grant
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.i_req = '0;
    #1;
    model_reset();
    for (int i = 0; i < 5; i++) cycle(3'b010, 3'b000, rnd_data());
    check("pre_arst_gnt", 32'(bus_if.o_gnt), 32'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();

    // Fairness after release: all requesting, every grant times out
    gq.delete();
    for (int i = 0; i < 6 * (MAX_HOLD + 1); i++) cycle('1, '0, rnd_data());
    check("fair_n", 32'(gq.size()), 32'd6);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      check($sformatf("fair%0d", i), 32'(gq[i]), 32'(i % N_REQ));

    // Request drop by owner 2 while requester 0 waits
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.i_req = '0;
    #1;
    model_reset();
    cycle(3'b100, 3'b000, rnd_data());
    for (int i = 0; i < 3; i++) cycle(3'b101, 3'b000, rnd_data());
    to_pulses = 0;
    gq.delete();
    cycle(3'b001, 3'b000, rnd_data());
    check("drop_turn_vld", 32'(bus_if.o_bus_vld), 32'h0);
    cycle(3'b001, 3'b000, rnd_data());
    check("drop_gnt", 32'(bus_if.o_gnt), 32'b001);
    check("drop_no_to", 32'(to_pulses), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [N_REQ-1:0] r, l;
      r = N_REQ'($urandom);
      l = ($urandom_range(0, 3) == 0) ? N_REQ'($urandom) : '0;
      cycle(r, l, rnd_data());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
